sdram_arbiter_mp: RTL
=====================

Name: sdram_arbiter_mp

Overview:
- Parametrised N-client arbiter between the frame/audio/init engines and the single 128-bit SDRAM bridge.
- Generalises the fixed-client arbiter with the following:
  - configurable client count;
  - per-client real-time priority mask with round-robin among the remaining clients;
  - an acknowledge timeout watchdog.
- One bridge transaction is outstanding at a time.
- Clients see the same wait/ac handshake used by the existing engines.

Parameters:
- NUM_CLIENTS, 6, number of client ports (2..8).
- ADDR_W, 22, client word address width (one word = 128 bits).
- DATA_W, 128, data width.
- BE_W, 16, byte-enable width (DATA_W/8).
- RT_MASK, 6'b110000, bit i=1 marks client i as real-time (fixed priority; higher index wins).
- TIMEOUT_CYC, 1024, cycles allowed in WAIT_ACK before abort.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  synchronous, active-low reset.
- cl_rd  in  NUM_CLIENTS  per-client read request, level, held until cl_ac.
- cl_wr  in  NUM_CLIENTS  per-client write request, level, held until cl_ac.
- cl_addr  in  NUM_CLIENTS*ADDR_W  packed word addresses; client i occupies slice i.
- cl_wrdata  in  NUM_CLIENTS*DATA_W  packed write data.
- cl_be  in  NUM_CLIENTS*BE_W  packed byte enables (writes only).
- cl_wait  out  NUM_CLIENTS  1 = request pending but not being served.
- cl_ac  out  NUM_CLIENTS  one-cycle completion pulse to the granted client.
- cl_rddata  out  DATA_W  registered read data, broadcast; valid in the cl_ac cycle.
- cl_err  out  1  high with cl_ac when the transaction timed out.
- br_addr  out  ADDR_W+4  byte address = {word addr, 4'b0000}.
- br_be  out  BE_W  byte enables (all ones on reads).
- br_read  out  1  bridge read strobe.
- br_write  out  1  bridge write strobe.
- br_wrdata  out  DATA_W  bridge write data.
- br_ack  in  1  bridge acknowledge.
- br_rddata  in  DATA_W  bridge read data, valid with br_ack.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky, set on any timeout.

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - state=IDLE; all outputs 0; last_grant=NUM_CLIENTS-1.
  - Reset mid-transaction drops br_read/br_write the next cycle; no cl_ac is issued.
- Request vector: req[i] = cl_rd[i] | cl_wr[i]. If both are set, the operation is a read.
- Arbitration (combinational; sampled in IDLE):
  - If any real-time request (req & RT_MASK), grant the highest-index real-time requester.
  - Otherwise grant round-robin among non-real-time requesters, starting at last_grant+1 and wrapping modulo NUM_CLIENTS.
  - last_grant updates only on non-real-time grants.
- States:
  - IDLE:
    - If req != 0: latch grant index, op, addr, wrdata and be (be forced to all ones on reads); go to ISSUE.
    - If req == 0: stay in IDLE.
  - ISSUE:
    - Drive br_addr/br_be/br_wrdata and assert br_read or br_write.
    - Clear the timeout counter; go to WAIT_ACK.
  - WAIT_ACK:
    - Hold strobe and address stable; increment the counter.
    - On br_ack: deassert strobe, register br_rddata into cl_rddata, go to RESP.
    - If the counter reaches TIMEOUT_CYC-1 without br_ack: deassert strobe, set cl_err_next=1, set timeout_err, go to RESP.
    - br_ack in the same cycle as expiry counts as success.
  - RESP:
    - cl_ac[grant]=1 for exactly this cycle.
    - cl_err=1 only if the transaction timed out.
    - Go to IDLE.
- Latency:
  - Minimum request-to-cl_ac is 4 cycles with br_ack in the first WAIT_ACK cycle.
  - A new grant is possible in the cycle after RESP.
- cl_wait[i] = req[i] & !(state != IDLE && grant == i), registered each cycle.
  - The granted client sees wait=0 from ISSUE through RESP.
- br_ack outside WAIT_ACK is ignored.
- Requests dropped before cl_ac have undefined effect on the bus, but the arbiter still completes and pulses cl_ac.
- cl_rddata holds its value until the next read completes.

Decomposition:
- Package sdram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_ACK, RESP);
  - op enum (OP_RD, OP_WR);
  - localparam WORD_BYTES=16.
- Sub-module rr_priority_picker (params NUM_CLIENTS, RT_MASK):
  - inputs req, last_grant;
  - outputs grant_valid, grant_idx;
  - purely combinational.
- FSM, latch registers and watchdog live in the top module.

Test Plan:
- Single write:
  - Stimulus: client 0 writes addr 22'h000123, be 16'h00FF, data 128'hA5..; bridge acks after 3 cycles.
  - Required: br_addr=26'h0001230, br_write held 3 cycles, cl_ac[0] one pulse, cl_err=0.
- Round-robin:
  - Stimulus: clients 0, 1, 2 request reads continuously; ack is immediate.
  - Required: grant order 0, 1, 2, 0; each cl_ac one cycle; non-served clients show cl_wait=1.
- Real-time preemption of the queue:
  - Stimulus: client 1 requests; client 5 requests one cycle later while client 1 is in WAIT_ACK.
  - Required: client 1 completes first, client 5 is granted next ahead of pending client 2.
- Timeout:
  - Stimulus: client 3 reads; br_ack is never asserted.
  - Required: strobe drops after TIMEOUT_CYC cycles, cl_ac[3] and cl_err pulse, timeout_err stays 1, the next request proceeds normally.
- Reset mid-transaction:
  - Stimulus: reset_n=0 during WAIT_ACK.
  - Required: next cycle br_read=0, busy=0, no cl_ac, last_grant=NUM_CLIENTS-1.
- Read data:
  - Stimulus: br_rddata=128'h0123..CDEF with br_ack.
  - Required: cl_rddata equals that value in the cl_ac cycle and holds afterwards.

Source files
------------

// File: rtl/sdram_arbiter_mp_pkg.sv
// Shared types for the multi-port SDRAM arbiter: FSM states, operation kind, word geometry.
// No logic, so no latency; flow control lives in the arbiter's wait/ac handshake.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam int WORD_BYTES = 16;

endpackage

// File: rtl/sdram_arbiter_mp_picker.sv
// Grant picker: highest-index real-time requester wins, else round-robin after last_grant.
// Purely combinational (0 cycles); never stalls, grant_valid is low only when req is empty.
module rr_priority_picker #(
  parameter int NUM_CLIENTS = 6,
  parameter int IDX_W = 3,
  parameter logic [NUM_CLIENTS-1:0] RT_MASK = 6'b110000
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  logic [NUM_CLIENTS-1:0] rt_req;
  logic [NUM_CLIENTS-1:0] nrt_req;
  logic                   rt_hit;
  logic                   rr_hit;
  logic [IDX_W-1:0]       rt_idx;
  logic [IDX_W-1:0]       rr_idx;
  int                     j;

  assign rt_req  = req & RT_MASK;
  assign nrt_req = req & ~RT_MASK;

  always_comb begin
    rt_hit = 1'b0;
    rt_idx = '0;
    rr_hit = 1'b0;
    rr_idx = '0;
    j      = 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (rt_req[i]) begin
        rt_hit = 1'b1;
        rt_idx = IDX_W'(i);
      end
    end
    // Scan farthest-first so the nearest requester after last_grant is written last.
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      j = (int'(last_grant) + k) % NUM_CLIENTS;
      if (nrt_req[j]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(j);
      end
    end
  end

  assign grant_valid = rt_hit | rr_hit;
  assign grant_idx   = rt_hit ? rt_idx : rr_idx;

endmodule

// File: rtl/sdram_arbiter_mp.sv
// N-client arbiter onto one 128-bit SDRAM bridge, one transaction in flight, with ack watchdog.
// Request to cl_ac in 3 + ack-wait cycles; clients stall on cl_wait, the bridge stalls us by withholding br_ack.
module sdram_arbiter_mp
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 6,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 128,
  parameter int BE_W = 16,
  parameter logic [NUM_CLIENTS-1:0] RT_MASK = 6'b110000,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS-1:0]        cl_rd,
  input  logic [NUM_CLIENTS-1:0]        cl_wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wrdata,
  input  logic [NUM_CLIENTS*BE_W-1:0]   cl_be,
  output logic [NUM_CLIENTS-1:0]        cl_wait,
  output logic [NUM_CLIENTS-1:0]        cl_ac,
  output logic [DATA_W-1:0]             cl_rddata,
  output logic                          cl_err,
  output logic [ADDR_W+3:0]             br_addr,
  output logic [BE_W-1:0]               br_be,
  output logic                          br_read,
  output logic                          br_write,
  output logic [DATA_W-1:0]             br_wrdata,
  input  logic                          br_ack,
  input  logic [DATA_W-1:0]             br_rddata,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t                 state;
  op_t                    op;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       pick;
  logic                   pick_vld;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wrdata_q;
  logic [BE_W-1:0]        be_q;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_CLIENTS-1:0] req;
  logic [NUM_CLIENTS-1:0] serve_mask;

  assign req = cl_rd | cl_wr;

  rr_priority_picker #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W(IDX_W),
    .RT_MASK(RT_MASK)
  ) u_picker (
    .req(req),
    .last_grant(last_grant),
    .grant_valid(pick_vld),
    .grant_idx(pick)
  );

  // Mask the client that will own the bus next cycle, so its wait is already low in ISSUE.
  always_comb begin
    serve_mask = '0;
    if (state != IDLE) serve_mask[grant] = 1'b1;
    else if (pick_vld) serve_mask[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      op          <= OP_RD;
      grant       <= '0;
      last_grant  <= LAST_IDX;
      addr_q      <= '0;
      wrdata_q    <= '0;
      be_q        <= '0;
      cnt         <= '0;
      cl_wait     <= '0;
      cl_ac       <= '0;
      cl_rddata   <= '0;
      cl_err      <= 1'b0;
      br_addr     <= '0;
      br_be       <= '0;
      br_read     <= 1'b0;
      br_write    <= 1'b0;
      br_wrdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cl_wait <= req & ~serve_mask;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= pick;
            if (!RT_MASK[pick]) last_grant <= pick;
            op       <= cl_rd[pick] ? OP_RD : OP_WR;
            addr_q   <= cl_addr[pick*ADDR_W +: ADDR_W];
            wrdata_q <= cl_wrdata[pick*DATA_W +: DATA_W];
            be_q     <= cl_rd[pick] ? {BE_W{1'b1}} : cl_be[pick*BE_W +: BE_W];
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          br_addr   <= {addr_q, {$clog2(WORD_BYTES){1'b0}}};
          br_be     <= be_q;
          br_wrdata <= wrdata_q;
          br_read   <= (op == OP_RD);
          br_write  <= (op == OP_WR);
          cnt       <= '0;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          cnt <= cnt + CNT_W'(1);
          // An ack arriving on the expiry cycle still wins over the watchdog.
          if (br_ack) begin
            br_read      <= 1'b0;
            br_write     <= 1'b0;
            if (op == OP_RD) cl_rddata <= br_rddata;
            cl_ac[grant] <= 1'b1;
            state        <= RESP;
          end else if (cnt == CNT_MAX) begin
            br_read      <= 1'b0;
            br_write     <= 1'b0;
            cl_err       <= 1'b1;
            timeout_err  <= 1'b1;
            cl_ac[grant] <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          cl_ac  <= '0;
          cl_err <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
